// File: rtl/accel_arbiter.sv
// accel_arbiter: round-robin scheduler sharing one accelerator between NREQ requesters,
// with operand latching, start pulse, result capture and a WAIT-state watchdog.
module accel_arbiter #(
  parameter int NREQ   = 4,
  parameter int TO_CYC = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [5*NREQ-1:0] reqV,
  input  logic [2*NREQ-1:0] reqU,
  output logic [NREQ-1:0]   ack,
  output logic [20:0]       resData,
  output logic              err,
  output logic              busy,
  output logic [2:0]        gntId,
  output logic              wStart,
  output logic [4:0]        v,
  output logic [1:0]        u,
  input  logic              wrReq,
  input  logic              wDone,
  input  logic [20:0]       wrData
);
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
  state_t r_state, w_state_n;
  logic [2:0] r_ptr, w_ptr_n, r_gnt, w_gnt_n, w_pick;
  logic [4:0] r_v, w_v_n;
  logic [1:0] r_u, w_u_n;
  logic [20:0] r_res, w_res_n;
  logic r_err, w_err_n, r_wstart, w_wstart_n, r_busy, w_busy_n;
  logic [NREQ-1:0] r_ack, w_ack_n;
  logic [11:0] r_cnt, w_cnt_n;
  always_comb begin
    w_pick = '0;
    for (int k = NREQ; k > 0; k--)
      if (req[(int'(r_ptr) + k) % NREQ]) w_pick = 3'((int'(r_ptr) + k) % NREQ);
    w_state_n  = r_state;
    w_ptr_n    = r_ptr;
    w_gnt_n    = r_gnt;
    w_v_n      = r_v;
    w_u_n      = r_u;
    w_res_n    = r_res;
    w_err_n    = r_err;
    w_cnt_n    = r_cnt;
    w_ack_n    = '0;
    w_wstart_n = 1'b0;
    case (r_state)
      IDLE: if (|req) begin
        w_state_n  = START;
        w_gnt_n    = w_pick;
        w_v_n      = reqV[5*w_pick +: 5];
        w_u_n      = reqU[2*w_pick +: 2];
        w_res_n    = '0;
        w_err_n    = 1'b0;
        w_cnt_n    = '0;
        w_wstart_n = 1'b1;
      end
      START: w_state_n = WAIT;
      WAIT: begin
        w_cnt_n = r_cnt + 12'd1;
        w_res_n = wrReq ? wrData : r_res;
        // completion beats the watchdog when both land in the same cycle
        if (wDone || r_cnt == 12'(TO_CYC - 1)) begin
          w_state_n = RESP;
          w_err_n   = !wDone;
          w_ack_n   = NREQ'(1) << r_gnt;
        end
      end
      default: begin
        w_ptr_n   = r_gnt;
        w_state_n = IDLE;
      end
    endcase
    w_busy_n = w_state_n != IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_ptr    <= 3'(NREQ - 1);
      r_gnt    <= 3'(NREQ - 1);
      r_v      <= '0;
      r_u      <= '0;
      r_res    <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_ack    <= '0;
      r_wstart <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_ptr    <= w_ptr_n;
      r_gnt    <= w_gnt_n;
      r_v      <= w_v_n;
      r_u      <= w_u_n;
      r_res    <= w_res_n;
      r_err    <= w_err_n;
      r_cnt    <= w_cnt_n;
      r_ack    <= w_ack_n;
      r_wstart <= w_wstart_n;
      r_busy   <= w_busy_n;
    end
  end
  assign ack     = r_ack;
  assign resData = r_res;
  assign err     = r_err;
  assign busy    = r_busy;
  assign gntId   = r_gnt;
  assign wStart  = r_wstart;
  assign v       = r_v;
  assign u       = r_u;
endmodule

// File: doc/accel_arbiter.md
# accel_arbiter

Round-robin scheduler that shares one `Accelerator` instance between `NREQ` requesters. It latches a requester's operands (`v`, `u`), pulses the accelerator's `wStart`, captures the result from `wrReq`/`wrData`, and returns it to the granted requester with a one-cycle `ack`. A watchdog aborts jobs that never signal `wDone`. It sits directly in front of `Accelerator`, replacing the bench/host that previously drove `wStart`/`v`/`u` by hand.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TO_CYC`, 4095: watchdog limit, in cycles spent in WAIT; the counter width is 12 bits.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `req`  in  NREQ  per-requester job request; held high until that requester's `ack`.
- `reqV`  in  5*NREQ  operand v, slice i = bits [5i+4:5i].
- `reqU`  in  2*NREQ  operand u, slice i = bits [2i+1:2i].
- `ack`  out  NREQ  one-cycle pulse to the served requester; `resData`/`err` are valid in that cycle.
- `resData`  out  21  captured accelerator result.
- `err`  out  1  high with `ack` if the job timed out.
- `busy`  out  1  high in every state except IDLE.
- `gntId`  out  3  index of the current or last granted requester.
- `wStart`  out  1  accelerator start pulse.
- `v`  out  5  operand to the accelerator.
- `u`  out  2  operand to the accelerator.
- `wrReq`  in  1  accelerator result-write strobe.
- `wDone`  in  1  accelerator completion.
- `wrData`  in  21  accelerator result.

## Operation
- State machine: IDLE, START, WAIT, RESP, all with registered outputs.
- **IDLE**
  - If `req` is nonzero, grant the first set bit searching upward from `ptr+1` and wrapping modulo `NREQ`.
  - Latch `gntId`, `v` and `u` from the granted slices; clear `resData`, `err` and the watchdog counter; go to START.
- **START**
  - `wStart`=1 for exactly this one cycle; `v`/`u` stay stable from the latch onward. Go to WAIT.
- **WAIT**
  - The watchdog counter increments every cycle.
  - If `wrReq` is high: `resData` <= `wrData`. The last `wrReq` before or at `wDone` wins.
  - If `wDone` is high: go to RESP.
  - Else if the counter equals `TO_CYC`-1: set `err`=1 and go to RESP.
- **RESP**
  - `ack[gntId]`=1 for one cycle; `ptr` <= `gntId`; go to IDLE.
- `v`/`u` hold their last latched values in IDLE.
- `resData`/`err` hold until the next grant.
- Requests that drop before `ack` do not cancel the job: the job completes and `ack` still pulses.
- `req` changes on other lines during a job are ignored until IDLE.
- Round-robin guarantees no starvation: with all lines requesting, each is served once per `NREQ` jobs.

## Timing
- **Reset values:** state=IDLE, `wStart`=0, `v`=0, `u`=0, `ack`=0, `resData`=0, `err`=0, `busy`=0, `gntId`=`NREQ`-1, `ptr`=`NREQ`-1. This makes the first grant go to index 0.
- **Cycle accounting**, with `req` seen in IDLE at cycle 0:
  - cycle 1: START, `wStart`=1.
  - cycle 2 onward: WAIT.
  - `wDone` seen at cycle d: `ack` at cycle d+1, IDLE at d+2.
  - A new grant is possible at d+2, so back-to-back jobs have a 2-cycle overhead plus the accelerator's own latency.
- **Simultaneous events:**
  - `wrReq` and `wDone` in the same cycle: data is captured and the job completes normally.
  - `wDone` in the watchdog's final cycle: completion wins and `err`=0.
  - `wDone`/`wrReq` seen outside WAIT are ignored.
- **Reset mid-job:** all registers return to reset values immediately, asynchronously. `wStart` drops at once and no `ack` is issued. The accelerator must itself be reset from the same `rst` net.

## Test plan
- **Single job with stub.** Stub accelerator asserts `wrReq`+`wDone` 20 cycles after `wStart`, with `wrData`={14'd0, u, v}. `req`=0001, v0=31, u0=0.
  - Required: one-cycle `wStart`; `ack`=0001 at 21 cycles after `wStart`; `resData`=21'h1F; `err`=0; `gntId`=0.
- **Fairness.** `req`=1111 held continuously, each requester with a distinct v (1, 2, 3, 4).
  - Required: grant order 0,1,2,3,0…; each `ack` paired with the matching `resData`; exactly one `wStart` per job.
- **Timeout.** Stub never asserts `wDone`, `TO_CYC`=16.
  - Required: `ack` with `err`=1 exactly 17 cycles after `wStart`; the next request is then served normally.
- **Boundary.**
  - `wDone` in the watchdog's final cycle: `err`=0.
  - Requester drops `req` mid-WAIT: its `ack` still pulses.
- **Reset mid-WAIT.** `rst`=0 for 2 cycles.
  - Required: all outputs at reset values immediately; no `ack`; a fresh request after release goes to index 0.
- **Integration with real `Accelerator`.** u=0; v=5'b11111, then v=5'b01111.
  - Required: `resData` bit-equal to the standalone `Accelerator`'s `wrData` for the same inputs (≈1.12873 and ≈1.0603); `err`=0.
